moore_seq_detector: RTL and testbench

Parametrised Moore serial pattern detector. Generalises the fixed 4-bit "1011" detector with a run-time loadable pattern of PAT_W bits, an overlap or non-overlap mode, input qualification and a saturating detection counter. It sits on any 1-bit serial stream, such as a UART bit slice or a framing/sync-word search. The output depends only on registered state.

---
 rtl/moore_seq_detector.sv | 112 +++++++++++
 tb/tb_moore_seq_detector.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector: run-time loadable pattern, overlap mode and a saturating hit counter.
// Defining SEQ_DET_MASK_EN adds a don't-care mask that is loaded together with the pattern.
module moore_seq_detector #(
  parameter int unsigned      PAT_W    = 4,
  parameter logic [PAT_W-1:0] PAT_INIT = 4'b1011,
  parameter bit               OVERLAP  = 1'b1,
  parameter int unsigned      CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in,
  input  logic             pattern_load,
  input  logic [PAT_W-1:0] pattern_in,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_W-1:0] pattern_mask_in,
`endif
  input  logic             count_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_count
);

  localparam int unsigned      FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              det_q, det_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PAT_W-1:0]  histShift;
  logic [FILL_W-1:0] fillInc;
  logic              patMatch;
  logic              hit;

`ifdef SEQ_DET_MASK_EN
  logic [PAT_W-1:0]  mask_q, mask_d;
`endif

  // A hit is judged on the history as it would look after taking this bit.
  always_comb begin
    histShift = {hist_q[PAT_W-2:0], in};
    fillInc   = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
`ifdef SEQ_DET_MASK_EN
    patMatch  = ((histShift ^ pat_q) & ~mask_q) == '0;
`else
    patMatch  = (histShift == pat_q);
`endif
    hit       = in_valid && !pattern_load && (fillInc == FILL_FULL) && patMatch;
  end

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    det_d  = det_q;
    cnt_d  = cnt_q;
`ifdef SEQ_DET_MASK_EN
    mask_d = mask_q;
`endif
    if (pattern_load) begin
      pat_d  = pattern_in;
      hist_d = '0;
      fill_d = '0;
      det_d  = 1'b0;
`ifdef SEQ_DET_MASK_EN
      mask_d = pattern_mask_in;
`endif
    end else if (in_valid) begin
      hist_d = histShift;
      fill_d = (hit && !OVERLAP) ? '0 : fillInc;
      det_d  = hit;
    end
    // Clear beats a simultaneous hit; otherwise count up and stick at all-ones.
    if (count_clr) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q  <= PAT_INIT;
      hist_q <= '0;
      fill_q <= '0;
      det_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      det_q  <= det_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef SEQ_DET_MASK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end
`endif

  assign out         = det_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_moore_seq_detector.sv
// Directed bench: three detector instances (overlap, non-overlap, 2-bit counter) share one stimulus stream.
module tb_moore_seq_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       inBit;
  logic       pattern_load;
  logic [3:0] pattern_in;
  logic [3:0] patternMask;
  logic       count_clr;
  logic       outA, outB, outC;
  logic [7:0] cntA, cntB;
  logic [1:0] cntC;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  moore_seq_detector #(.PAT_W(4), .PAT_INIT(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dutA (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(inBit),
    .pattern_load(pattern_load), .pattern_in(pattern_in),
`ifdef SEQ_DET_MASK_EN
    .pattern_mask_in(patternMask),
`endif
    .count_clr(count_clr), .out(outA), .match_count(cntA)
  );

  moore_seq_detector #(.PAT_W(4), .PAT_INIT(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dutB (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(inBit),
    .pattern_load(pattern_load), .pattern_in(pattern_in),
`ifdef SEQ_DET_MASK_EN
    .pattern_mask_in(patternMask),
`endif
    .count_clr(count_clr), .out(outB), .match_count(cntB)
  );

  moore_seq_detector #(.PAT_W(4), .PAT_INIT(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dutC (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(inBit),
    .pattern_load(pattern_load), .pattern_in(pattern_in),
`ifdef SEQ_DET_MASK_EN
    .pattern_mask_in(patternMask),
`endif
    .count_clr(count_clr), .out(outC), .match_count(cntC)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One clock with the given bit offered; outputs are sampled 1ns after the edge.
  task automatic applyStimulus(input logic valid, input logic bitVal);
    in_valid = valid;
    inBit    = bitVal;
    @(posedge clk);
    #1;
  endtask

  // Sends n bits (MSB first) and checks out of A and B after each, with optional idle gaps.
  task automatic sendBits(input logic [15:0] bits, input int n, input logic [15:0] expA,
                          input logic [15:0] expB, input int gap, input string tag);
    logic b;
    for (int i = 0; i < n; i++) begin
      b = bits[n-1-i];
      applyStimulus(1'b1, b);
      checkOutput($sformatf("%s_a%0d", tag, i), outA, expA[n-1-i]);
      checkOutput($sformatf("%s_b%0d", tag, i), outB, expB[n-1-i]);
      for (int g = 0; g < gap; g++) begin
        applyStimulus(1'b0, (g % 2 == 0) ? ~b : b);
        checkOutput($sformatf("%s_idleA%0d_%0d", tag, i, g), outA, expA[n-1-i]);
        checkOutput($sformatf("%s_idleB%0d_%0d", tag, i, g), outB, expB[n-1-i]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset        = 1'b0;
    in_valid     = 1'b0;
    inBit        = 1'b0;
    pattern_load = 1'b0;
    pattern_in   = 4'b0000;
    patternMask  = 4'b0000;
    count_clr    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_outA", outA, 0);
    checkOutput("rst_cntA", cntA, 0);
    checkOutput("rst_cntB", cntB, 0);
    reset = 1'b1;

    // Overlapping vs non-overlapping on 1011011, then 1011 again.
    sendBits(16'b1011011, 7, 16'b0001001, 16'b0001000, 0, "t1");
    checkOutput("t1_cntA", cntA, 2);
    checkOutput("t1_cntB", cntB, 1);
    sendBits(16'b1011, 4, 16'b0001, 16'b0001, 0, "t2");
    checkOutput("t2_cntA", cntA, 3);
    checkOutput("t2_cntB", cntB, 2);
    checkOutput("t2_cntC", cntC, 3);

    // Idle gaps are transparent and out holds through them.
    doReset();
    sendBits(16'b1011011, 7, 16'b0001001, 16'b0001000, 2, "t3");
    checkOutput("t3_cntA", cntA, 2);
    checkOutput("t3_cntB", cntB, 1);

    // Pattern load wins over a valid bit, clears det but keeps the count.
    pattern_in   = 4'b0110;
    pattern_load = 1'b1;
    applyStimulus(1'b1, 1'b1);
    pattern_load = 1'b0;
    in_valid     = 1'b0;
    checkOutput("t4_load_outA", outA, 0);
    checkOutput("t4_load_cntA", cntA, 2);
    sendBits(16'b0110110, 7, 16'b0001001, 16'b0001000, 0, "t4");
    checkOutput("t4_cntA", cntA, 4);
    checkOutput("t4_cntB", cntB, 2);

    // Asynchronous reset mid-cycle drops the partial match and restores 1011.
    sendBits(16'b101, 3, 16'b000, 16'b000, 0, "t5pre");
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t5_async_cntA", cntA, 0);
    checkOutput("t5_async_cntB", cntB, 0);
    checkOutput("t5_async_outA", outA, 0);
    reset = 1'b1;
    sendBits(16'b1, 1, 16'b0, 16'b0, 0, "t5one");
    checkOutput("t5_one_cntA", cntA, 0);
    sendBits(16'b1011, 4, 16'b0001, 16'b0001, 0, "t5");
    checkOutput("t5_cntA", cntA, 1);
    checkOutput("t5_cntB", cntB, 1);

    // Four more overlapping hits: C saturates at 3, B hits every other triple.
    for (int k = 0; k < 4; k++) begin
      sendBits(16'b011, 3, 16'b001, (k % 2 == 1) ? 16'b001 : 16'b000, 0, $sformatf("t6_%0d", k));
    end
    checkOutput("t6_cntA", cntA, 5);
    checkOutput("t6_cntB", cntB, 3);
    checkOutput("t6_cntC_sat", cntC, 3);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    count_clr = 1'b1;
    applyStimulus(1'b1, 1'b1);
    count_clr = 1'b0;
    in_valid  = 1'b0;
    checkOutput("t6_clr_outA", outA, 1);
    checkOutput("t6_clr_cntA", cntA, 0);
    checkOutput("t6_clr_cntB", cntB, 0);
    checkOutput("t6_clr_cntC", cntC, 0);
    sendBits(16'b011, 3, 16'b001, 16'b001, 0, "t6post");
    checkOutput("t6_post_cntA", cntA, 1);
    checkOutput("t6_post_cntB", cntB, 1);
    checkOutput("t6_post_cntC", cntC, 1);

`ifdef SEQ_DET_MASK_EN
    // Masked position 2 lets 1111 match pattern 1011.
    pattern_in   = 4'b1011;
    patternMask  = 4'b0100;
    pattern_load = 1'b1;
    applyStimulus(1'b0, 1'b0);
    pattern_load = 1'b0;
    sendBits(16'b1111, 4, 16'b0001, 16'b0001, 0, "t7mask");
    checkOutput("t7_cntA", cntA, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
